// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for the shared ALU
module alu_arbiter #(
    parameter int WIDTH = 4,
    parameter int SHW   = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic [SHW-1:0]   r0_shamt,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic [SHW-1:0]   r1_shamt,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_z,
    output logic             rsp_o,
    output logic             rsp_c,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SHW-1:0]   alu_shamt,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_z,
    input  logic             alu_o,
    input  logic             alu_c,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SHW-1:0]   sh_q, sh_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             z_q, z_d;
    logic             o_q, o_d;
    logic             c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             gnt0, gnt1;

    // Round-robin grant: a lone requester always wins, contention resolves to prio_q
    always_comb begin
        gnt1     = r1_valid && (!r0_valid || prio_q);
        gnt0     = r0_valid && !gnt1;
        r0_ready = (state_q == IDLE) && gnt0;
        r1_ready = (state_q == IDLE) && gnt1;
    end

    // Next-state: accept in IDLE, sample ALU in EXEC, hold response until taken
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        sh_d    = sh_q;
        s_d     = s_q;
        z_d     = z_q;
        o_d     = o_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    id_d    = gnt1;
                    prio_d  = !gnt1;
                    a_d     = gnt1 ? r1_a : r0_a;
                    b_d     = gnt1 ? r1_b : r0_b;
                    sh_d    = gnt1 ? r1_shamt : r0_shamt;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                s_d     = alu_s;
                z_d     = alu_z;
                o_d     = alu_o;
                c_d     = alu_c;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    // State and datapath registers; reset discards any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sh_q        <= '0;
            s_q         <= '0;
            z_q         <= 1'b0;
            o_q         <= 1'b0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sh_q        <= sh_d;
            s_q         <= s_d;
            z_q         <= z_d;
            o_q         <= o_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_shamt = sh_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_s     = s_q;
    assign rsp_z     = z_q;
    assign rsp_o     = o_q;
    assign rsp_c     = c_q;
    assign busy      = busy_q;
    assign ops_done  = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r0_valid = 1'b0, r1_valid = 1'b0, rsp_ready = 1'b0;
    logic [3:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic [2:0] r0_shamt = '0, r1_shamt = '0;
    logic       r0_ready, r1_ready, rsp_valid, rsp_id, rsp_z, rsp_o, rsp_c, busy;
    logic [3:0] rsp_s, alu_a, alu_b, alu_s;
    logic [2:0] alu_shamt;
    logic       alu_z, alu_o, alu_c;
    logic [7:0] ops_done;
    logic       d2_r0_ready, d2_r1_ready, d2_rsp_valid, d2_rsp_id, d2_rsp_z, d2_rsp_o, d2_rsp_c, d2_busy;
    logic [3:0] d2_rsp_s, d2_alu_a, d2_alu_b;
    logic [2:0] d2_alu_shamt;
    logic [1:0] d2_ops_done;
    logic [4:0] sum;

    always #5 clk = ~clk;

    // Behavioural ALU stub: add with carry, zero and signed overflow
    assign sum   = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_s = sum[3:0];
    assign alu_c = sum[4];
    assign alu_z = (sum[3:0] == 4'd0);
    assign alu_o = (alu_a[3] == alu_b[3]) && (sum[3] != alu_a[3]);

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_shamt(r0_shamt),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_shamt(r1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_s(rsp_s),
        .rsp_z(rsp_z), .rsp_o(rsp_o), .rsp_c(rsp_c),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_s(alu_s), .alu_z(alu_z), .alu_o(alu_o), .alu_c(alu_c),
        .busy(busy), .ops_done(ops_done)
    );

    alu_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(d2_r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_shamt(r0_shamt),
        .r1_valid(r1_valid), .r1_ready(d2_r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_shamt(r1_shamt),
        .rsp_valid(d2_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(d2_rsp_id), .rsp_s(d2_rsp_s),
        .rsp_z(d2_rsp_z), .rsp_o(d2_rsp_o), .rsp_c(d2_rsp_c),
        .alu_a(d2_alu_a), .alu_b(d2_alu_b), .alu_shamt(d2_alu_shamt),
        .alu_s(alu_s), .alu_z(alu_z), .alu_o(alu_o), .alu_c(alu_c),
        .busy(d2_busy), .ops_done(d2_ops_done)
    );

    int tests = 0, fails = 0, cyc = 0;
    bit checking = 0;
    // Transaction-level reference: one operation in flight, aged in cycles since acceptance
    bit m_busy = 0, m_prio = 0, m_id = 0;
    int m_age = 0, m_cnt = 0, m_a = 0, m_b = 0, m_sh = 0;
    bit last_hs0 = 0, last_hs1 = 0, rsp_hs = 0;
    int gq[$], gcyc[$], rq[$], wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_rsp_word(input int id, input int a, input int b);
        int s, sa, sb, ss, c, z, o;
        s  = (a + b) % 16;
        c  = (a + b) > 15;
        z  = (s == 0);
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        ss = sa + sb;
        o  = (ss > 7) || (ss < -8);
        return (id << 7) | (s << 3) | (z << 2) | (o << 1) | c;
    endfunction

    // One clock: compare outputs mid-cycle, advance reference model at the edge
    task automatic cycle();
        bit e0, e1, g1, rv;
        #1;
        g1 = r1_valid && (!r0_valid || m_prio);
        e0 = !m_busy && r0_valid && !g1;
        e1 = !m_busy && g1;
        rv = m_busy && (m_age >= 2);
        if (checking) begin
            chk("r0_ready", r0_ready, e0);
            chk("r1_ready", r1_ready, e1);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, rv);
            chk("ops_done", ops_done, m_cnt % 256);
            chk("ops_done_w2", d2_ops_done, m_cnt % 4);
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_shamt", alu_shamt, m_sh);
            if (rv) chk("rsp_word", {rsp_id, rsp_s, rsp_z, rsp_o, rsp_c}, exp_rsp_word(m_id, m_a, m_b));
        end
        rsp_hs = !rst && rv && rsp_ready;
        if (rsp_hs) rq.push_back({rsp_id, rsp_s, rsp_z, rsp_o, rsp_c});
        @(posedge clk);
        if (rst) begin
            m_busy = 0; m_prio = 0; m_id = 0; m_age = 0; m_cnt = 0; m_a = 0; m_b = 0; m_sh = 0;
        end else if (!m_busy) begin
            if (e0 || e1) begin
                m_busy = 1; m_age = 1; m_id = e1; m_prio = !e1;
                m_a = e1 ? r1_a : r0_a; m_b = e1 ? r1_b : r0_b; m_sh = e1 ? r1_shamt : r0_shamt;
                gq.push_back(int'(e1)); gcyc.push_back(cyc);
            end
        end else if (m_age == 1) begin
            m_age = 2;
        end else if (rsp_ready) begin
            m_busy = 0; m_cnt++;
        end
        last_hs0 = !rst && e0;
        last_hs1 = !rst && e1;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        gq.delete(); gcyc.delete(); rq.delete();
    endtask

    initial begin
        // Reset state
        r0_valid = 0; r1_valid = 0;
        cycle();
        checking = 1;
        cycle();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ops_done", ops_done, 0);
        chk("rst_alu_a", alu_a, 0);

        // Single request: 3 + 5
        rsp_ready = 1; r0_a = 3; r0_b = 5; r0_shamt = 2; r0_valid = 1;
        #1 chk("single_r0_ready", r0_ready, 1);
        cycle();
        r0_valid = 0;
        cycle();
        #1 chk("single_rsp", {rsp_valid, rsp_id, rsp_s, rsp_z, rsp_o, rsp_c}, 9'h142);
        cycle();
        chk("single_ops_done", ops_done, 1);

        // Contention from reset release
        r0_a = 7; r0_b = 1; r1_a = 15; r1_b = 1; r0_valid = 1; r1_valid = 1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            if (last_hs0) r0_valid = 0;
            if (last_hs1) r1_valid = 0;
            cycle();
        end
        chk("cont_rsp_count", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("cont_rsp0", rq[0], 32'h42);
            chk("cont_rsp1", rq[1], 32'h85);
            chk("cont_gap", gcyc[1] - gcyc[0], 3);
        end

        // Fairness: both valid continuously for 8 operations
        r0_valid = 1; r1_valid = 1;
        do_reset();
        for (int i = 0; i < 100 && rq.size() < 8; i++) begin
            if (last_hs0) begin r0_a = 4'($urandom); r0_b = 4'($urandom); end
            if (last_hs1) begin r1_a = 4'($urandom); r1_b = 4'($urandom); end
            cycle();
        end
        chk("fair_count", ops_done, 8);
        for (int i = 0; i < 8 && i < gq.size(); i++) chk("fair_grant", gq[i], i % 2);

        // Back-pressure: hold the response 5 cycles with both requesters waiting
        r0_valid = 1; r1_valid = 0; rsp_ready = 0;
        do_reset();
        cycle(); r0_valid = 0; cycle();
        r0_valid = 1; r1_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_hold", {rsp_valid, busy, r0_ready, r1_ready}, 4'b1100);
            cycle();
        end
        rsp_ready = 1;
        cycle();
        chk("bp_done", ops_done, 1);

        // Reset during EXEC discards the operation and re-arbitrates from prio 0
        r0_valid = 1; r1_valid = 0;
        do_reset();
        cycle(); r0_valid = 0; cycle(); cycle();
        r0_valid = 1; r1_valid = 1;
        #1 chk("midop_r1_granted", r1_ready, 1);
        cycle();
        rst = 1;
        cycle();
        rst = 0;
        #1 chk("midop_after", {rsp_valid, busy, ops_done, r0_ready, r1_ready}, 12'b0_0_00000000_1_0);
        cycle();

        // Counter wrap on the 2-bit instance
        r0_valid = 1; r1_valid = 0;
        do_reset();
        wq.delete();
        for (int i = 0; i < 40 && wq.size() < 5; i++) begin
            cycle();
            if (rsp_hs) wq.push_back(int'(d2_ops_done));
        end
        chk("wrap_count", wq.size(), 5);
        for (int i = 0; i < wq.size(); i++) chk("wrap_seq", wq[i], (i + 1) % 4);

        // Randomized traffic obeying the requester rules
        r0_valid = 0; r1_valid = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (!r0_valid || last_hs0) begin
                r0_valid = ($urandom_range(0, 2) != 0);
                r0_a = 4'($urandom); r0_b = 4'($urandom); r0_shamt = 3'($urandom);
            end
            if (!r1_valid || last_hs1) begin
                r1_valid = ($urandom_range(0, 2) != 0);
                r1_a = 4'($urandom); r1_b = 4'($urandom); r1_shamt = 3'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
